register_dump: RTL
==================

REGISTER_DUMP -- requirements
Module: register_dump

Interface
REQ-001: Parameter l, default 16, register width in bits; SHALL be a multiple of 8.
REQ-002: Parameter a, default 3, register address width; register count r = 2^a.
REQ-003: Clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-004: ResetN  input  1  asynchronous, active-low reset.
REQ-005: DebugData  input  l*r  register-file image; register i occupies bits [i*l +: l].
REQ-006: Start  input  1  request a dump; sampled on the rising edge.
REQ-007: OutReady  input  1  downstream can accept a byte this cycle.
REQ-008: OutByte  output  8  current frame byte.
REQ-009: OutValid  output  1  OutByte holds a valid byte.
REQ-010: Busy  output  1  high from Start acceptance until Done.
REQ-011: Done  output  1  one-cycle pulse when the frame is complete.

Function
REQ-012: The block SHALL serialize one register-file image as a byte frame: header 0xA5, then registers 0..r-1, each MS byte first (l/8 bytes per register), then one checksum byte.
REQ-013: Frame length SHALL be 2 + r*l/8 bytes (18 with the default parameters).
REQ-014: The checksum SHALL be the bitwise XOR of all data bytes; the header SHALL NOT be included.
REQ-015: The FSM states SHALL be IDLE, HEADER, DATA, CHECK and FINISH.
REQ-016: In IDLE with Start=1 at edge N, the block SHALL snapshot DebugData into an internal buffer and enter HEADER.
REQ-017: From edge N, OutValid=1 and OutByte=0xA5 (zero-cycle gap after acceptance).
REQ-018: A byte transfers on an edge where OutValid=1 and OutReady=1.
REQ-019: The next byte SHALL be presented on the following cycle, with no idle cycle between bytes.
REQ-020: While OutValid=1 and OutReady=0, OutByte and the internal state SHALL hold unchanged.
REQ-021: HEADER -> DATA on header transfer.
REQ-022: DATA SHALL hold a byte counter from 0 to r*l/8-1, updating the running XOR on each transfer.
REQ-023: DATA -> CHECK on transfer of the last data byte.
REQ-024: CHECK -> FINISH on checksum transfer.
REQ-025: FINISH SHALL assert Done=1 and OutValid=0 for exactly one cycle, then return to IDLE.
REQ-026: Busy SHALL be 1 in HEADER, DATA, CHECK and FINISH, and 0 in IDLE.
REQ-027: Start SHALL be ignored when not in IDLE; no restart and no queuing.
REQ-028: Changes on DebugData after acceptance SHALL NOT affect the frame in progress.
REQ-029: OutValid SHALL be 0 in IDLE and FINISH; OutByte SHALL be 0x00 whenever OutValid=0.
REQ-030: Start held high continuously SHALL begin a new frame on the cycle after FINISH.
REQ-031: OutReady held at 1 throughout SHALL complete a default-parameter frame in 18 transfer cycles plus 1 FINISH cycle.

Reset
REQ-032: ResetN=0 SHALL immediately and asynchronously force state IDLE, OutValid=0, OutByte=0x00, Busy=0 and Done=0, and clear the byte counter, checksum and snapshot.
REQ-033: Reset asserted mid-frame SHALL abandon the frame, with no Done pulse.
REQ-034: After ResetN returns high, the first rising edge with Start=1 SHALL start a fresh frame.

Verification
REQ-035: Registers 0x0001..0x0008, Start pulse, OutReady=1 -> A5 00 01 00 02 ... 00 08 08, then Done for 1 cycle, Busy low afterwards.
REQ-036: All registers 0x0000 -> A5, sixteen 00 bytes, checksum 00.
REQ-037: OutReady=0 for 5 cycles while byte 3 (0x00) is presented -> OutByte and OutValid stable for 5 cycles; frame continues unchanged afterwards.
REQ-038: Start pulsed again mid-frame, and DebugData changed to 0xFFFF everywhere after acceptance -> original frame unchanged; exactly one Done.
REQ-039: ResetN pulsed low during DATA -> outputs zero immediately; no Done; a subsequent Start yields a complete, correct 18-byte frame.
REQ-040: Start held high with OutReady=1 -> back-to-back frames separated by exactly one FINISH cycle.

Source files
------------

// File: rtl/register_dump.sv
// Purpose : serializes a snapshot of a register file as a byte frame: 0xA5, data bytes (MS byte first), XOR checksum.
// Latency : header byte is presented from the same edge that accepts Start; bytes follow with no idle gaps.
// Backpressure: valid/ready handshake on OutValid/OutReady; byte and state hold while OutReady is low.
//
// Ports:
//   Clk, ResetN         - clock, async active-low reset
//   DebugData [l*r]     - register image, register i at [i*l +: l]
//   Start               - dump request (accepted when idle, or in the FINISH cycle)
//   OutReady            - downstream accepts OutByte this cycle
//   OutByte/OutValid    - frame byte stream (OutByte is 0x00 when not valid)
//   Busy                - frame in progress, including the FINISH cycle
//   Done                - one-cycle pulse after the checksum byte transfers
module register_dump #(
  parameter int l = 16,
  parameter int a = 3
) (
  input  logic                  Clk,
  input  logic                  ResetN,
  input  logic [l*(2**a)-1:0]   DebugData,
  input  logic                  Start,
  input  logic                  OutReady,
  output logic [7:0]            OutByte,
  output logic                  OutValid,
  output logic                  Busy,
  output logic                  Done
);

  localparam int R      = 2**a;
  localparam int NB     = l / 8;
  localparam int NBYTES = R * NB;
  localparam int CW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  typedef enum logic [2:0] {IDLE, HEADER, DATA, CHECK, FINISH} state_t;

  state_t              r_state;
  logic [l*R-1:0]      r_snap;
  logic [CW-1:0]       r_cnt;
  logic [7:0]          r_xor;
  logic [7:0]          r_out_byte;
  logic                r_out_valid;
  logic                r_busy;
  logic                r_done;

  logic [7:0]          w_first_byte;
  logic [7:0]          w_next_byte;
  logic                w_last;

  // Frame data byte k: register k/NB, byte k%NB counted from the MS end.
  function automatic logic [7:0] byte_at(input logic [l*R-1:0] img, input int k);
    int idx;
    if (k >= NBYTES) return 8'h00;
    idx = (k / NB) * NB + (NB - 1 - (k % NB));
    return img[idx*8 +: 8];
  endfunction

  assign w_first_byte = byte_at(r_snap, 0);
  assign w_next_byte  = byte_at(r_snap, int'(r_cnt) + 1);
  assign w_last       = (r_cnt == CW'(NBYTES - 1));

  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      r_state     <= IDLE;
      r_snap      <= '0;
      r_cnt       <= '0;
      r_xor       <= 8'h00;
      r_out_byte  <= 8'h00;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      case (r_state)
        // FINISH shares the idle acceptance path so a held Start restarts
        // right after the single FINISH cycle without an extra idle cycle.
        IDLE, FINISH: begin
          r_done <= 1'b0;
          if (Start) begin
            r_snap      <= DebugData;
            r_cnt       <= '0;
            r_xor       <= 8'h00;
            r_out_byte  <= 8'hA5;
            r_out_valid <= 1'b1;
            r_busy      <= 1'b1;
            r_state     <= HEADER;
          end else begin
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        HEADER: begin
          if (OutReady) begin
            r_cnt      <= '0;
            r_out_byte <= w_first_byte;
            r_state    <= DATA;
          end
        end
        DATA: begin
          if (OutReady) begin
            r_xor <= r_xor ^ r_out_byte;
            if (w_last) begin
              // Checksum includes the byte transferring on this edge.
              r_out_byte <= r_xor ^ r_out_byte;
              r_state    <= CHECK;
            end else begin
              r_cnt      <= r_cnt + 1'b1;
              r_out_byte <= w_next_byte;
            end
          end
        end
        CHECK: begin
          if (OutReady) begin
            r_out_byte  <= 8'h00;
            r_out_valid <= 1'b0;
            r_done      <= 1'b1;
            r_state     <= FINISH;
          end
        end
        default: begin
          r_out_byte  <= 8'h00;
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_done      <= 1'b0;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign OutByte  = r_out_byte;
  assign OutValid = r_out_valid;
  assign Busy     = r_busy;
  assign Done     = r_done;

endmodule
